// File: rtl/pn_seq_pkg.sv
// Shared types, legal-state constants and the next-state function for the
// {A,B} PN-flip-flop sequence 00 -> 11 -> 01 -> 10 -> 00.
package pn_seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [1:0] PN_S0 = 2'b00;
  localparam logic [1:0] PN_S1 = 2'b11;
  localparam logic [1:0] PN_S2 = 2'b01;
  localparam logic [1:0] PN_S3 = 2'b10;

  // A' = ~A, B' = ~(A ^ B)
  function automatic logic [1:0] pn_nxt(input logic [1:0] s);
    return {~s[1], ~(s[1] ^ s[0])};
  endfunction

endpackage

// File: rtl/pn_seq_next.sv
// Combinational next-symbol lookup for the PN sequence; also used by the
// generator's bench model.
module pn_seq_next
  import pn_seq_pkg::*;
(
  input  logic [1:0] cur,
  output logic [1:0] nxt_c
);

  always_comb begin
    nxt_c = pn_nxt(cur);
    case (cur)
      PN_S0:   nxt_c = PN_S1;
      PN_S1:   nxt_c = PN_S2;
      PN_S2:   nxt_c = PN_S3;
      PN_S3:   nxt_c = PN_S0;
      default: nxt_c = pn_nxt(cur);
    endcase
  end

endmodule

// File: rtl/pn_seq_checker.sv
// Lock/flywheel checker for the PN-flip-flop {A,B} sequence with saturating
// error/good counters. Define PN_SEQ_CHECKER_STICKY_EN to add err_sticky.
module pn_seq_checker
  import pn_seq_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned CW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [1:0]    state_in,
  output logic          locked,
  output logic [1:0]    expected,
  output logic          err_pulse,
  output logic          sync_lost,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] good_cnt
`ifdef PN_SEQ_CHECKER_STICKY_EN
  ,
  output logic          err_sticky
`endif
);

  localparam int unsigned RW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

  chk_state_t    state_q, state_d;
  logic [1:0]    exp_q, exp_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic [CW-1:0] err_q, err_d, good_q, good_d;
  logic          locked_q, locked_d;
  logic          err_pulse_q, err_pulse_d;
  logic          sync_lost_q, sync_lost_d;
  logic [1:0]    nxt_in, nxt_exp;
  logic          match;
`ifdef PN_SEQ_CHECKER_STICKY_EN
  logic          sticky_q, sticky_d;
`endif

  pn_seq_next u_nxt_in  (.cur(state_in), .nxt_c(nxt_in));
  pn_seq_next u_nxt_exp (.cur(exp_q),    .nxt_c(nxt_exp));

  assign match    = (state_in == exp_q);
  assign run_inc  = run_q + RW'(1);
  assign miss_inc = miss_q + MW'(1);

  // Next-state: hunt/acquire reseed from the input, locked flywheels on its own prediction
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_d       = err_q;
    good_d      = good_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    sync_lost_d = 1'b0;
`ifdef PN_SEQ_CHECKER_STICKY_EN
    sticky_d    = sticky_q;
`endif
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          exp_d   = nxt_in;
          run_d   = '0;
          state_d = ACQ;
        end
        ACQ: begin
          exp_d = nxt_in;
          if (match) begin
            run_d = run_inc;
            if (run_inc == RW'(LOCK_COUNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          exp_d = nxt_exp;
          if (match) begin
            good_d = (good_q == {CW{1'b1}}) ? good_q : good_q + CW'(1);
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_d       = (err_q == {CW{1'b1}}) ? err_q : err_q + CW'(1);
            miss_d      = miss_inc;
`ifdef PN_SEQ_CHECKER_STICKY_EN
            sticky_d    = 1'b1;
`endif
            if (miss_inc == MW'(MISS_LIMIT)) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              sync_lost_d = 1'b1;
              miss_d      = '0;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      exp_q       <= 2'b00;
      run_q       <= '0;
      miss_q      <= '0;
      err_q       <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_lost_q <= 1'b0;
`ifdef PN_SEQ_CHECKER_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      sync_lost_q <= sync_lost_d;
`ifdef PN_SEQ_CHECKER_STICKY_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign locked    = locked_q;
  assign expected  = exp_q;
  assign err_pulse = err_pulse_q;
  assign sync_lost = sync_lost_q;
  assign err_cnt   = err_q;
  assign good_cnt  = good_q;
`ifdef PN_SEQ_CHECKER_STICKY_EN
  assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_pn_seq_checker.sv
// Directed bench for pn_seq_checker: a default instance, a CW=2 instance and
// a LOCK_COUNT=1/MISS_LIMIT=1 instance share one input stream.
module tb_pn_seq_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] state_in;

  logic       a_lk, a_ep, a_sl, b_lk, b_ep, b_sl, c_lk, c_ep, c_sl;
  logic [1:0] a_ex, b_ex, c_ex;
  logic [7:0] a_ec, a_gc, c_ec, c_gc;
  logic [1:0] b_ec, b_gc;
`ifdef PN_SEQ_CHECKER_STICKY_EN
  logic       a_st, b_st, c_st;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pn_seq_checker #(.LOCK_COUNT(4), .MISS_LIMIT(3), .CW(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .state_in(state_in),
    .locked(a_lk), .expected(a_ex), .err_pulse(a_ep), .sync_lost(a_sl),
    .err_cnt(a_ec), .good_cnt(a_gc)
`ifdef PN_SEQ_CHECKER_STICKY_EN
    , .err_sticky(a_st)
`endif
  );

  pn_seq_checker #(.LOCK_COUNT(4), .MISS_LIMIT(3), .CW(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .state_in(state_in),
    .locked(b_lk), .expected(b_ex), .err_pulse(b_ep), .sync_lost(b_sl),
    .err_cnt(b_ec), .good_cnt(b_gc)
`ifdef PN_SEQ_CHECKER_STICKY_EN
    , .err_sticky(b_st)
`endif
  );

  pn_seq_checker #(.LOCK_COUNT(1), .MISS_LIMIT(1), .CW(8)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .state_in(state_in),
    .locked(c_lk), .expected(c_ex), .err_pulse(c_ep), .sync_lost(c_sl),
    .err_cnt(c_ec), .good_cnt(c_gc)
`ifdef PN_SEQ_CHECKER_STICKY_EN
    , .err_sticky(c_st)
`endif
  );

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       lk;
    logic [1:0] ex;
    logic       ep;
    logic       sl;
    int         ec;
    int         gc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [1:0] s, input logic lk, input logic [1:0] ex,
                     input logic ep, input logic sl, input int ec, input int gc);
    vec_t r;
    r.v = v; r.s = s; r.lk = lk; r.ex = ex; r.ep = ep; r.sl = sl; r.ec = ec; r.gc = gc;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s);
    in_valid = v;
    state_in = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_nxt(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b11;
      2'b11:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  initial begin
    logic [1:0] mexp;
    logic       sticky_m;
    string      p;

    // v  s      lk ex     ep sl ec gc
    add(1, 2'b00, 0, 2'b11, 0, 0, 0, 0);   // seed
    add(1, 2'b11, 0, 2'b01, 0, 0, 0, 0);
    add(1, 2'b01, 0, 2'b10, 0, 0, 0, 0);
    add(1, 2'b10, 0, 2'b00, 0, 0, 0, 0);
    add(1, 2'b00, 1, 2'b11, 0, 0, 0, 0);   // 4th correct transition locks
    add(1, 2'b11, 1, 2'b01, 0, 0, 0, 1);
    add(1, 2'b00, 1, 2'b10, 1, 0, 1, 1);   // 01 replaced by 00
    add(1, 2'b10, 1, 2'b00, 0, 0, 1, 2);
    add(1, 2'b00, 1, 2'b11, 0, 0, 1, 3);
    add(0, 2'b01, 1, 2'b11, 0, 0, 1, 3);   // in_valid low x3
    add(0, 2'b01, 1, 2'b11, 0, 0, 1, 3);
    add(0, 2'b01, 1, 2'b11, 0, 0, 1, 3);
    add(1, 2'b11, 1, 2'b01, 0, 0, 1, 4);
    add(1, 2'b01, 1, 2'b10, 0, 0, 1, 5);
    add(1, 2'b11, 1, 2'b00, 1, 0, 2, 5);   // three misses in a row
    add(1, 2'b11, 1, 2'b11, 1, 0, 3, 5);
    add(1, 2'b00, 0, 2'b01, 1, 1, 4, 5);
    add(0, 2'b00, 0, 2'b01, 0, 0, 4, 5);   // pulses drop while idle
    add(1, 2'b10, 0, 2'b00, 0, 0, 4, 5);   // reseed from HUNT
    add(1, 2'b01, 0, 2'b10, 0, 0, 4, 5);   // ACQ miss: reseed, no error
    add(1, 2'b10, 0, 2'b00, 0, 0, 4, 5);
    add(1, 2'b00, 0, 2'b11, 0, 0, 4, 5);
    add(1, 2'b11, 0, 2'b01, 0, 0, 4, 5);
    add(1, 2'b01, 1, 2'b10, 0, 0, 4, 5);   // re-locked
    add(1, 2'b10, 1, 2'b00, 0, 0, 4, 6);

    reset = 1'b0; in_valid = 1'b0; state_in = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst locked",    32'(a_lk), 0);
    chk("rst expected",  32'(a_ex), 0);
    chk("rst err_pulse", 32'(a_ep), 0);
    chk("rst sync_lost", 32'(a_sl), 0);
    chk("rst err_cnt",   32'(a_ec), 0);
    chk("rst good_cnt",  32'(a_gc), 0);
`ifdef PN_SEQ_CHECKER_STICKY_EN
    chk("rst sticky",    32'(a_st), 0);
`endif

    sticky_m = 1'b0;
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s);
      p = $sformatf("row%0d", i);
      chk({p, " locked"},    32'(a_lk), 32'(tbl[i].lk));
      chk({p, " expected"},  32'(a_ex), 32'(tbl[i].ex));
      chk({p, " err_pulse"}, 32'(a_ep), 32'(tbl[i].ep));
      chk({p, " sync_lost"}, 32'(a_sl), 32'(tbl[i].sl));
      chk({p, " err_cnt"},   32'(a_ec), 32'(tbl[i].ec));
      chk({p, " good_cnt"},  32'(a_gc), 32'(tbl[i].gc));
      chk({p, " cw2 locked"},   32'(b_lk), 32'(tbl[i].lk));
      chk({p, " cw2 err_cnt"},  32'(b_ec), 32'(sat3(tbl[i].ec)));
      chk({p, " cw2 good_cnt"}, 32'(b_gc), 32'(sat3(tbl[i].gc)));
      sticky_m = sticky_m | tbl[i].ep;
`ifdef PN_SEQ_CHECKER_STICKY_EN
      chk({p, " sticky"}, 32'(a_st), 32'(sticky_m));
`endif
    end

    // Spaced errors while locked: each miss is followed by a match
    mexp = 2'b00;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, ~mexp);
      mexp = model_nxt(mexp);
      p = $sformatf("spaced%0d", k);
      chk({p, " err_pulse"},   32'(a_ep), 1);
      chk({p, " locked"},      32'(a_lk), 1);
      chk({p, " err_cnt"},     32'(a_ec), 32'(5 + k));
      chk({p, " cw2 err_cnt"}, 32'(b_ec), 3);
      chk({p, " cw2 locked"},  32'(b_lk), 1);
      step(1'b1, mexp);
      mexp = model_nxt(mexp);
      chk({p, " match good_cnt"}, 32'(a_gc), 32'(7 + k));
      chk({p, " match expected"}, 32'(a_ex), 32'(mexp));
    end

    // Async reset while an error pulse is in flight
    step(1'b1, ~mexp);
    chk("inflight err_pulse", 32'(a_ep), 1);
    #2 reset = 1'b0;
    #1;
    chk("async locked",    32'(a_lk), 0);
    chk("async expected",  32'(a_ex), 0);
    chk("async err_pulse", 32'(a_ep), 0);
    chk("async sync_lost", 32'(a_sl), 0);
    chk("async err_cnt",   32'(a_ec), 0);
    chk("async good_cnt",  32'(a_gc), 0);
    chk("async cw2 err",   32'(b_ec), 0);
`ifdef PN_SEQ_CHECKER_STICKY_EN
    chk("async sticky",    32'(a_st), 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // LOCK_COUNT=1 / MISS_LIMIT=1 corner on dut_c
    step(1'b1, 2'b00);
    chk("lc1 seed locked",   32'(c_lk), 0);
    chk("lc1 seed expected", 32'(c_ex), 32'(2'b11));
    step(1'b1, 2'b11);
    chk("lc1 locked",        32'(c_lk), 1);
    chk("lc1 default still acq", 32'(a_lk), 0);
    step(1'b1, 2'b00);
    chk("ml1 sync_lost",     32'(c_sl), 1);
    chk("ml1 locked",        32'(c_lk), 0);
    chk("ml1 err_cnt",       32'(c_ec), 1);
    step(1'b1, 2'b00);
    step(1'b1, 2'b11);
    chk("ml1 relock",        32'(c_lk), 1);
`ifdef PN_SEQ_CHECKER_STICKY_EN
    chk("sticky survives relock", 32'(c_st), 1);
    chk("sticky clean instance",  32'(a_st), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
